// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax denominator accumulator.
// mf8_t is the 8-bit mantissa / 8-bit biased exponent mini-float.
// A mantissa of 0x00 encodes zero; otherwise bit 7 is set.
package softmax_pkg;

  typedef struct packed {
    logic [7:0] mant;
    logic [7:0] exp;
  } mf8_t;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    ALIGN,
    ADD,
    DONE
  } acc_state_e;

  localparam mf8_t       MF8_ZERO = '{mant: 8'h00, exp: 8'h00};
  localparam logic [7:0] EXP_MAX  = 8'd255;

endpackage

// File: rtl/mf8_align_add.sv
// Combinational mini-float align (first half) and add/normalise (second half).
// Latency: none; the caller registers between the two halves.
// Backpressure: none, pure datapath.
module mf8_align_add
  import softmax_pkg::*;
(
  input  mf8_t       acc,
  input  mf8_t       elem,
  output logic [7:0] al_big_m,
  output logic [7:0] al_small_m,
  output logic [7:0] al_res_e,
  input  logic [7:0] add_big_m,
  input  logic [7:0] add_small_m,
  input  logic [7:0] add_res_e,
  output mf8_t       add_sum,
  output logic       add_sat
);

  logic [7:0] diff;
  logic [8:0] sum9;

  // Align: shift the smaller-exponent mantissa right; a zero operand passes the other through.
  always_comb begin
    diff       = 8'd0;
    al_big_m   = acc.mant;
    al_small_m = 8'd0;
    al_res_e   = acc.exp;
    if (acc.mant == 8'd0) begin
      // Empty accumulator: the element becomes the sum with no carry possible.
      al_big_m = elem.mant;
      al_res_e = elem.exp;
    end else if (elem.mant == 8'd0) begin
      // Zero element: accumulator flows through unchanged.
      al_big_m = acc.mant;
    end else if (acc.exp >= elem.exp) begin
      diff       = acc.exp - elem.exp;
      al_big_m   = acc.mant;
      al_small_m = (diff >= 8'd8) ? 8'd0 : (elem.mant >> diff[2:0]);
      al_res_e   = acc.exp;
    end else begin
      diff       = elem.exp - acc.exp;
      al_big_m   = elem.mant;
      al_small_m = (diff >= 8'd8) ? 8'd0 : (acc.mant >> diff[2:0]);
      al_res_e   = elem.exp;
    end
  end

  // Add and renormalise by at most one bit; saturate when the exponent would wrap.
  always_comb begin
    sum9    = {1'b0, add_big_m} + {1'b0, add_small_m};
    add_sat = 1'b0;
    add_sum = '{mant: sum9[7:0], exp: add_res_e};
    if (sum9[8]) begin
      if (add_res_e == EXP_MAX) begin
        add_sum = '{mant: 8'hFF, exp: EXP_MAX};
        add_sat = 1'b1;
      end else begin
        add_sum = '{mant: sum9[8:1], exp: add_res_e + 8'd1};
      end
    end
  end

endmodule

// File: rtl/softmax_accum_seq.sv
// Sequences align -> add -> normalise over N streamed mini-float terms into one sum.
// Latency: 1 cycle start->in_ready, 3 cycles per element, 3 cycles last handshake->sum_valid.
// Backpressure: in_ready only in ACCEPT; the FSM waits there indefinitely for in_valid.
module softmax_accum_seq
  import softmax_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int MANT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [7:0]        in_exp,
  output logic              sum_valid,
  output logic [MANT_W-1:0] sum_mant,
  output logic [7:0]        sum_exp,
  output logic              busy,
  output logic              overflow
);

  acc_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  mf8_t             acc_q;
  mf8_t             elem_q;
  mf8_t             sum_q;
  logic [7:0]       big_q, small_q, res_q;
  logic             ovf_q;

  logic [7:0]       al_big_m, al_small_m, al_res_e;
  mf8_t             add_sum;
  logic             add_sat;

  mf8_align_add u_align_add (
    .acc         (acc_q),
    .elem        (elem_q),
    .al_big_m    (al_big_m),
    .al_small_m  (al_small_m),
    .al_res_e    (al_res_e),
    .add_big_m   (big_q),
    .add_small_m (small_q),
    .add_res_e   (res_q),
    .add_sum     (add_sum),
    .add_sat     (add_sat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    sum_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = (len != '0) ? ACCEPT : DONE;
      end
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ALIGN;
      end
      ALIGN:   state_d = ADD;
      ADD:     state_d = (cnt_q == len_q) ? DONE : ACCEPT;
      DONE: begin
        sum_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; the sum output loads only on entry to DONE and holds afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= MF8_ZERO;
      elem_q  <= MF8_ZERO;
      sum_q   <= MF8_ZERO;
      big_q   <= 8'd0;
      small_q <= 8'd0;
      res_q   <= 8'd0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q <= len;
            cnt_q <= '0;
            acc_q <= MF8_ZERO;
            ovf_q <= 1'b0;
            if (len == '0) sum_q <= MF8_ZERO;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            elem_q <= '{mant: in_mant, exp: in_exp};
            cnt_q  <= cnt_q + LEN_W'(1);
          end
        end
        ALIGN: begin
          big_q   <= al_big_m;
          small_q <= al_small_m;
          res_q   <= al_res_e;
        end
        ADD: begin
          acc_q <= add_sum;
          if (add_sat) ovf_q <= 1'b1;
          if (cnt_q == len_q) sum_q <= add_sum;
        end
        default: ;
      endcase
    end
  end

  assign sum_mant = sum_q.mant;
  assign sum_exp  = sum_q.exp;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_softmax_accum_seq.sv
// Scoreboard bench for softmax_accum_seq: directed cases, gaps, ignored start, reset abort, random streams.
module tb_softmax_accum_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_mant = 8'd0;
  logic [7:0] in_exp = 8'd0;
  logic       sum_valid;
  logic [7:0] sum_mant;
  logic [7:0] sum_exp;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] m;
    logic [7:0] e;
    logic       ov;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] em[16];
  logic [7:0] ee[16];

  softmax_accum_seq #(.LEN_W(8), .MANT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .sum_valid (sum_valid),
    .sum_mant  (sum_mant),
    .sum_exp   (sum_exp),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Monitor: every sum_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t x;
    if (!rst && sum_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_sum", {31'd0, sum_valid}, 32'd0);
      end else begin
        x = sb.pop_front();
        chk("sum_mant", {24'd0, sum_mant}, {24'd0, x.m});
        chk("sum_exp", {24'd0, sum_exp}, {24'd0, x.e});
        chk("sum_ovf", {31'd0, overflow}, {31'd0, x.ov});
      end
    end
  end

  // Independent integer reference for one accumulate step.
  task automatic mdl_add(inout int am, inout int ae, inout logic ov, input int m, input int e);
    int bm, sm, re, s;
    if (am == 0) begin
      am = m; ae = e;
    end else if (m != 0) begin
      if (ae >= e) begin
        bm = am; re = ae; sm = (ae - e >= 8) ? 0 : (m / (1 << (ae - e)));
      end else begin
        bm = m; re = e; sm = (e - ae >= 8) ? 0 : (am / (1 << (e - ae)));
      end
      s = bm + sm;
      if (s > 255) begin
        if (re == 255) begin am = 255; ae = 255; ov = 1'b1; end
        else begin am = s / 2; ae = re + 1; end
      end else begin
        am = s; ae = re;
      end
    end
  endtask

  // Drive one request from em/ee; optional idle gap (and ignored start) before element gap_at.
  task automatic run_req(input int n, input logic [7:0] wm, input logic [7:0] we, input logic wov,
                         input int gap_at, input int gap_len, input bit poke);
    exp_t x;
    int   w;
    int   k;
    x.m = wm; x.e = we; x.ov = wov;
    sb.push_back(x);
    start = 1'b1; len = n[7:0];
    @(posedge clk); #1;
    start = 1'b0;
    chk("ovf_clr_on_start", {31'd0, overflow}, 32'd0);
    if (n == 0) begin
      chk("len0_valid_lat", {31'd0, sum_valid}, 32'd1);
      @(posedge clk); #1;
      chk("len0_idle", {31'd0, busy}, 32'd0);
      return;
    end
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("rdy_lat", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < n; i++) begin
      w = 0;
      if (i == gap_at) begin
        repeat (gap_len) begin @(posedge clk); #1; end
        chk("gap_wait_rdy", {31'd0, in_ready}, 32'd1);
        if (poke) begin
          start = 1'b1; len = 8'd1;
          @(posedge clk); #1;
          start = 1'b0; len = n[7:0];
          chk("poke_busy", {31'd0, busy}, 32'd1);
          chk("poke_rdy", {31'd0, in_ready}, 32'd1);
        end
      end
      in_valid = 1'b1; in_mant = em[i]; in_exp = ee[i];
      while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
      if (w >= 50) chk("hs_timeout", {31'd0, in_ready}, 32'd1);
      if (i > 0 && i != gap_at) chk("thru_gap", w, 2);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    k = 1;
    while (!sum_valid && k < 8) begin @(posedge clk); #1; k++; end
    chk("sum_lat", k, 3);
    @(posedge clk); #1;
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    chk("valid_pulse", {31'd0, sum_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   am, ae, n;
    logic ov;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum_mant, sum_exp}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    em[0] = 8'h80; ee[0] = 8'd10;
    run_req(1, 8'h80, 8'd10, 1'b0, -1, 0, 1'b0);

    em[0] = 8'h80; ee[0] = 8'd10; em[1] = 8'h80; ee[1] = 8'd10;
    run_req(2, 8'h80, 8'd11, 1'b0, -1, 0, 1'b0);

    em[0] = 8'hC0; ee[0] = 8'd12; em[1] = 8'h80; ee[1] = 8'd10;
    run_req(2, 8'hE0, 8'd12, 1'b0, -1, 0, 1'b0);

    em[0] = 8'h80; ee[0] = 8'd20; em[1] = 8'hFF; ee[1] = 8'd10;
    run_req(2, 8'h80, 8'd20, 1'b0, -1, 0, 1'b0);

    // Zero element mid-stream, 5-cycle input gap and an ignored start while busy.
    em[0] = 8'h80; ee[0] = 8'd20; em[1] = 8'h00; ee[1] = 8'd5; em[2] = 8'h80; ee[2] = 8'd20;
    run_req(3, 8'h80, 8'd21, 1'b0, 1, 5, 1'b1);

    em[0] = 8'h80; ee[0] = 8'd255; em[1] = 8'h80; ee[1] = 8'd255;
    run_req(2, 8'hFF, 8'd255, 1'b1, -1, 0, 1'b0);
    chk("ovf_sticky_idle", {31'd0, overflow}, 32'd1);

    run_req(0, 8'h00, 8'd0, 1'b0, -1, 0, 1'b0);

    // Reset while in ADD: aborts the request with no sum pulse.
    em[0] = 8'hA0; ee[0] = 8'd7;
    start = 1'b1; len = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_mant = 8'hA0; in_exp = 8'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_sum_valid", {31'd0, sum_valid}, 32'd0);
    chk("abort_ovf", {31'd0, overflow}, 32'd0);
    chk("abort_sum", {16'd0, sum_mant, sum_exp}, 32'd0);
    @(posedge clk); #1;
    chk("abort_no_pulse", {31'd0, sum_valid}, 32'd0);

    // Random streams checked against the integer reference.
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 6);
      am = 0; ae = 0; ov = 1'b0;
      for (int i = 0; i < n; i++) begin
        em[i] = ($urandom_range(0, 4) == 0) ? 8'h00 : (8'h80 | 8'($urandom_range(0, 127)));
        ee[i] = (r == 4) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 40));
        mdl_add(am, ae, ov, int'(em[i]), int'(ee[i]));
      end
      run_req(n, am[7:0], ae[7:0], ov, -1, 0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
